// File: rtl/execute_mem_s2_access.sv
// execute_mem_s2_access: single-outstanding dmem access stage with one-cycle ROB writeback.
// Optional EXECUTE_MEM_S2_ALIGN_CHECK_EN faults misaligned word accesses instead of aligning them down.
module execute_mem_s2_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        bco_valid,
  input  logic        i_valid,
  input  logic [3:0]  i_dst_rob,
  input  logic [7:0]  i_fid,
  input  logic        i_s_byte,
  input  logic        i_s_store,
  input  logic        i_s_load,
  input  logic [31:0] i_src1_value,
  input  logic [31:0] i_agu_p_addr,
  input  logic        i_agu_p_uncached,
  output logic        o_busy,
  output logic        o_dmem_req_valid,
  input  logic        i_dmem_req_ready,
  output logic [31:0] o_dmem_req_addr,
  output logic        o_dmem_req_write,
  output logic        o_dmem_req_uncached,
  output logic [3:0]  o_dmem_req_strb,
  output logic [31:0] o_dmem_req_wdata,
  input  logic        i_dmem_resp_valid,
  input  logic [31:0] i_dmem_resp_data,
  output logic        o_wb_valid,
  output logic [3:0]  o_wb_dst_rob,
  output logic [7:0]  o_wb_fid,
  output logic [31:0] o_wb_value,
  output logic        o_wb_exception
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;
  state_t      state_q, state_d;
  logic        killed_q, killed_d;
  logic        exc_q, exc_d;
  logic [31:0] val_q, val_d;
  logic [3:0]  rob_q;
  logic [7:0]  fid_q;
  logic        byte_q, store_q, unc_q;
  logic [31:0] addr_q, data_q;
  logic        accept, mem_op, misal, in_req;
  assign accept = i_valid & ~bco_valid & ((state_q == IDLE) | (state_q == WB));
  assign mem_op = i_s_load | i_s_store;
`ifdef EXECUTE_MEM_S2_ALIGN_CHECK_EN
  assign misal = mem_op & ~i_s_byte & (i_agu_p_addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    val_d    = val_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE, WB: begin
        state_d = IDLE;
        if (accept) begin
          state_d = (!mem_op || misal) ? WB : REQ;
          val_d   = misal ? i_agu_p_addr : 32'h0;
          exc_d   = misal;
        end
      end
      REQ: begin
        // A request already handed to dmem still owes a response, so a flush only marks it killed.
        if (i_dmem_req_ready) begin
          state_d  = WAIT;
          killed_d = bco_valid;
        end else if (bco_valid) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bco_valid) killed_d = 1'b1;
        if (i_dmem_resp_valid) begin
          state_d  = (killed_q || bco_valid) ? IDLE : WB;
          killed_d = 1'b0;
          val_d    = store_q ? 32'h0 :
                     byte_q  ? {24'h0, i_dmem_resp_data[{addr_q[1:0], 3'b000} +: 8]} :
                               i_dmem_resp_data;
          exc_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      killed_q <= 1'b0;
      exc_q    <= 1'b0;
      val_q    <= 32'h0;
      rob_q    <= 4'h0;
      fid_q    <= 8'h0;
      byte_q   <= 1'b0;
      store_q  <= 1'b0;
      unc_q    <= 1'b0;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      exc_q    <= exc_d;
      val_q    <= val_d;
      if (accept) begin
        rob_q   <= i_dst_rob;
        fid_q   <= i_fid;
        byte_q  <= i_s_byte;
        store_q <= i_s_store;
        unc_q   <= i_agu_p_uncached;
        addr_q  <= i_agu_p_addr;
        data_q  <= i_src1_value;
      end
    end
  end
  assign in_req              = (state_q == REQ);
  assign o_busy              = in_req | (state_q == WAIT);
  assign o_dmem_req_valid    = in_req;
  assign o_dmem_req_addr     = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign o_dmem_req_write    = in_req & store_q;
  assign o_dmem_req_uncached = in_req & unc_q;
  assign o_dmem_req_strb     = !in_req ? 4'h0 : (store_q && byte_q) ? (4'b0001 << addr_q[1:0]) : 4'hF;
  assign o_dmem_req_wdata    = !(in_req && store_q) ? 32'h0 : byte_q ? {4{data_q[7:0]}} : data_q;
  assign o_wb_valid          = (state_q == WB);
  assign o_wb_dst_rob        = rob_q;
  assign o_wb_fid            = fid_q;
  assign o_wb_value          = val_q;
  assign o_wb_exception      = exc_q;
endmodule

// File: tb/tb_execute_mem_s2_access.sv
// tb_execute_mem_s2_access: randomized transaction-level check of execute_mem_s2_access against an op-level model.
module tb_execute_mem_s2_access;
  logic        clk = 0, resetn = 0, bco_valid = 0, i_valid = 0;
  logic [3:0]  i_dst_rob = 0;
  logic [7:0]  i_fid = 0;
  logic        i_s_byte = 0, i_s_store = 0, i_s_load = 0, i_agu_p_uncached = 0;
  logic [31:0] i_src1_value = 0, i_agu_p_addr = 0, i_dmem_resp_data = 0;
  logic        i_dmem_req_ready = 0, i_dmem_resp_valid = 0;
  logic        o_busy, o_dmem_req_valid, o_dmem_req_write, o_dmem_req_uncached;
  logic [31:0] o_dmem_req_addr, o_dmem_req_wdata, o_wb_value;
  logic [3:0]  o_dmem_req_strb, o_wb_dst_rob;
  logic [7:0]  o_wb_fid;
  logic        o_wb_valid, o_wb_exception;
  int total = 0, bad = 0;
`ifdef EXECUTE_MEM_S2_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  execute_mem_s2_access dut (
    .clk(clk), .resetn(resetn), .bco_valid(bco_valid),
    .i_valid(i_valid), .i_dst_rob(i_dst_rob), .i_fid(i_fid),
    .i_s_byte(i_s_byte), .i_s_store(i_s_store), .i_s_load(i_s_load),
    .i_src1_value(i_src1_value), .i_agu_p_addr(i_agu_p_addr), .i_agu_p_uncached(i_agu_p_uncached),
    .o_busy(o_busy), .o_dmem_req_valid(o_dmem_req_valid), .i_dmem_req_ready(i_dmem_req_ready),
    .o_dmem_req_addr(o_dmem_req_addr), .o_dmem_req_write(o_dmem_req_write),
    .o_dmem_req_uncached(o_dmem_req_uncached), .o_dmem_req_strb(o_dmem_req_strb),
    .o_dmem_req_wdata(o_dmem_req_wdata), .i_dmem_resp_valid(i_dmem_resp_valid),
    .i_dmem_resp_data(i_dmem_resp_data), .o_wb_valid(o_wb_valid), .o_wb_dst_rob(o_wb_dst_rob),
    .o_wb_fid(o_wb_fid), .o_wb_value(o_wb_value), .o_wb_exception(o_wb_exception)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (resetn && i_valid && o_busy) $error("protocol: i_valid while busy");

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // kind: 0 load, 1 store, 2 neither. bco_ph: 0 none, 1 in REQ without ready, 2 with handshake, 3 in WAIT.
  task automatic op(input int kind, input bit b, input logic [31:0] a, input logic [31:0] d,
                    input int rdly, input int sdly, input logic [31:0] resp,
                    input int bco_ph, input int bco_at);
    logic [3:0]  rob;
    logic [7:0]  fid;
    logic        unc;
    logic [31:0] exp_val;
    bit          misal, killed;
    rob = 4'($urandom);
    fid = 8'($urandom);
    unc = 1'($urandom);
    misal = ALIGN && kind != 2 && !b && a[1:0] != 2'b00;
    exp_val = (kind == 1) ? 32'h0 : b ? ((resp >> (8 * a[1:0])) & 32'hFF) : resp;
    chk("busy_idle", 32'(o_busy), 32'h0);
    i_valid = 1; i_dst_rob = rob; i_fid = fid; i_s_byte = b;
    i_s_load = (kind == 0); i_s_store = (kind == 1);
    i_src1_value = d; i_agu_p_addr = a; i_agu_p_uncached = unc;
    step;
    i_valid = 0; i_src1_value = $urandom; i_agu_p_addr = $urandom;
    if (kind == 2 || misal) begin
      chk("direct_wb_valid", 32'(o_wb_valid), 32'h1);
      chk("direct_req_valid", 32'(o_dmem_req_valid), 32'h0);
      chk("direct_value", o_wb_value, misal ? a : 32'h0);
      chk("direct_exc", 32'(o_wb_exception), 32'(misal));
      chk("direct_rob", 32'(o_wb_dst_rob), 32'(rob));
      return;
    end
    for (int k = 0; ; k++) begin
      chk("req_valid", 32'(o_dmem_req_valid), 32'h1);
      chk("req_busy", 32'(o_busy), 32'h1);
      chk("req_addr", o_dmem_req_addr, {a[31:2], 2'b00});
      chk("req_write", 32'(o_dmem_req_write), 32'(kind == 1));
      chk("req_unc", 32'(o_dmem_req_uncached), 32'(unc));
      chk("req_strb", 32'(o_dmem_req_strb), (kind == 1 && b) ? (32'd1 << a[1:0]) : 32'hF);
      if (kind == 1) chk("req_wdata", o_dmem_req_wdata, b ? {24'h0, d[7:0]} * 32'h01010101 : d);
      if (bco_ph == 1 && k == bco_at) begin
        bco_valid = 1; i_dmem_req_ready = 0;
        step;
        bco_valid = 0;
        chk("withdraw_req", 32'(o_dmem_req_valid), 32'h0);
        chk("withdraw_busy", 32'(o_busy), 32'h0);
        chk("withdraw_wb", 32'(o_wb_valid), 32'h0);
        return;
      end
      i_dmem_req_ready = (k == rdly);
      bco_valid = (bco_ph == 2 && k == rdly);
      step;
      i_dmem_req_ready = 0; bco_valid = 0;
      if (k >= rdly) break;
    end
    killed = (bco_ph == 2);
    for (int j = 0; j <= sdly; j++) begin
      chk("wait_busy", 32'(o_busy), 32'h1);
      chk("wait_req", 32'(o_dmem_req_valid), 32'h0);
      chk("wait_wb", 32'(o_wb_valid), 32'h0);
      if (bco_ph == 3 && j == bco_at) begin
        bco_valid = 1; killed = 1;
      end
      i_dmem_resp_valid = (j == sdly);
      i_dmem_resp_data = (j == sdly) ? resp : $urandom;
      step;
      bco_valid = 0; i_dmem_resp_valid = 0;
    end
    if (killed) begin
      chk("killed_wb", 32'(o_wb_valid), 32'h0);
      chk("killed_busy", 32'(o_busy), 32'h0);
    end else begin
      chk("wb_valid", 32'(o_wb_valid), 32'h1);
      chk("wb_rob", 32'(o_wb_dst_rob), 32'(rob));
      chk("wb_fid", 32'(o_wb_fid), 32'(fid));
      chk("wb_value", o_wb_value, exp_val);
      chk("wb_exc", 32'(o_wb_exception), 32'h0);
      chk("wb_busy", 32'(o_busy), 32'h0);
    end
  endtask

  initial begin
    step; step;
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_req", 32'(o_dmem_req_valid), 32'h0);
    chk("rst_addr", o_dmem_req_addr, 32'h0);
    chk("rst_strb", 32'(o_dmem_req_strb), 32'h0);
    chk("rst_wb", 32'(o_wb_valid), 32'h0);
    chk("rst_value", o_wb_value, 32'h0);
    resetn = 1;
    step;
    op(0, 0, 32'h0000_1004, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0);
    op(1, 1, 32'h0000_8002, 32'h12345678, 0, 0, 32'h5555_AAAA, 0, 0);
    op(0, 1, 32'h0000_2003, 32'h0, 0, 1, 32'hA1B2C3D4, 0, 0);
    step;
    op(0, 0, 32'h0000_3000, 32'h0, 9, 0, 32'h1111_2222, 1, 5);
    op(0, 0, 32'h0000_3100, 32'h0, 0, 2, 32'h3333_4444, 3, 0);
    op(0, 0, 32'h0000_3200, 32'h0, 1, 0, 32'h5555_6666, 0, 0);
    op(0, 0, 32'h0000_4001, 32'h0, 0, 0, 32'h7777_8888, 0, 0);
    op(1, 0, 32'h0000_4003, 32'hCAFEF00D, 0, 0, 32'h0, 0, 0);
    op(2, 0, 32'h0000_5000, 32'h0, 0, 0, 32'h0, 0, 0);
    op(0, 0, 32'h0000_5100, 32'h0, 1, 1, 32'h9999_0000, 2, 0);
    step;
    // reset asserted in WAIT; the orphaned response afterwards must be ignored
    i_valid = 1; i_s_load = 1; i_s_store = 0; i_agu_p_addr = 32'h6000;
    step;
    i_valid = 0; i_dmem_req_ready = 1;
    step;
    i_dmem_req_ready = 0;
    chk("pre_rst_busy", 32'(o_busy), 32'h1);
    resetn = 0;
    #1;
    chk("async_rst_busy", 32'(o_busy), 32'h0);
    chk("async_rst_wb", 32'(o_wb_valid), 32'h0);
    step;
    resetn = 1; i_dmem_resp_valid = 1; i_dmem_resp_data = 32'hBAD0BAD0;
    step;
    i_dmem_resp_valid = 0;
    chk("orphan_wb", 32'(o_wb_valid), 32'h0);
    chk("orphan_busy", 32'(o_busy), 32'h0);
    for (int n = 0; n < 200; n++) begin
      int kind, ph, rd, sd, at, r;
      r = $urandom_range(0, 9);
      kind = (r < 5) ? 0 : (r < 9) ? 1 : 2;
      r = $urandom_range(0, 5);
      ph = (r < 3) ? 0 : r - 2;
      rd = $urandom_range(0, 3);
      sd = $urandom_range(0, 3);
      at = (ph == 1) ? $urandom_range(0, rd) : (ph == 3) ? $urandom_range(0, sd) : 0;
      if ($urandom_range(0, 3) == 0) begin
        step;
        chk("gap_wb", 32'(o_wb_valid), 32'h0);
      end
      op(kind, 1'($urandom), $urandom, $urandom, rd, sd, $urandom, ph, at);
    end
    step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
